clock_hms_param: RTL and testbench
==================================

// Module: clock_hms_param
// PURPOSE
//   Parametrised hour/minute/second timekeeper with an integrated set state machine, runtime 12/24-hour
//   display mode, an external time-load port and a built-in six-digit 7-segment display multiplexer.
//   It replaces the separate setter, clock and decoder instances used by earlier clocks. A single clk
//   is used: one-second timing comes from an internal divider, not from a second clock input.
// PARAMETERS
//   TICK_DIV   50_000_000  clk cycles per second; must be >= 2
//   BLINK_DIV  12_500_000  clk cycles per blink half-period for the field being edited; must be >= 1
// PORTS
//   clk           in   1  system clock; all state changes on the rising edge
//   reset         in   1  asynchronous, active-high reset
//   pulsed_set    in   1  one-cycle pulse: advance the set FSM
//   pulsed_up     in   1  one-cycle pulse: increment the field being edited
//   pulsed_down   in   1  one-cycle pulse: decrement the field being edited
//   mode_12h      in   1  1 = show hours in 12-hour form on disp5/disp4; 0 = 24-hour form
//   load_valid    in   1  one-cycle pulse: load load_hours and load_minutes (honoured in RUN only)
//   load_hours    in   5  hour to load, 0..23
//   load_minutes  in   6  minute to load, 0..59
//   hours         out  5  current hour, 0..23 (always 24-hour form)
//   minutes       out  6  current minute, 0..59
//   seconds       out  6  current second, 0..59
//   is_pm         out  1  1 when hours >= 12
//   current_state out  2  0 = RUN, 1 = SET_H, 2 = SET_M
//   propagate     out  1  one-cycle pulse when a set value is committed
//   disp5..disp0  out  7  segments {g,f,e,d,c,b,a}, active-high; disp5/4 = hour tens/units,
//                         disp3/2 = minute tens/units, disp1/0 = second tens/units
// BEHAVIOUR
//   Reset (asynchronous): time = 00:00:00, divider = 0, FSM = RUN, shadow registers = 0, propagate = 0,
//     blink phase = 0, is_pm = 0.
//   Divider: counts 0..TICK_DIV-1. sec_tick is asserted for the single cycle in which the divider equals
//     TICK_DIV-1; the divider then wraps to 0.
//   Counting: on sec_tick, seconds increments. 59 -> 0 carries into minutes; minute 59 -> 0 carries into
//     hours; hour 23 -> 0 with no further carry. 23:59:59 -> 00:00:00. Time keeps counting in every FSM state.
//   FSM:
//     RUN   --pulsed_set--> SET_H. On this entry: shadow_h = hours, shadow_m = minutes.
//     SET_H --pulsed_set--> SET_M
//     SET_M --pulsed_set--> RUN. On this commit: hours = shadow_h, minutes = shadow_m, seconds = 0,
//       divider = 0, propagate = 1 in the following cycle (registered, exactly one cycle wide).
//   Editing: in SET_H, up/down changes shadow_h modulo 24. In SET_M, up/down changes shadow_m modulo 60.
//     Examples: 23 + 1 = 0; 0 - 1 = 59.
//   Simultaneous inputs:
//     up and down in the same cycle: no change.
//     set together with up or down: set wins and the up/down pulse is dropped.
//     commit and sec_tick in the same cycle: the commit wins.
//   load_valid in RUN: hours = load_hours, minutes = load_minutes, seconds = 0, divider = 0. propagate is
//     not asserted. Out-of-range load values (hours > 23 or minutes > 59) are ignored as a whole.
//     load_valid is ignored in SET_H and SET_M. load_valid together with pulsed_set in RUN: the set wins.
//   Display in RUN: digits show hours:minutes:seconds. If mode_12h = 1 the hour shown is 12 for hour 0,
//     hours-12 for hours 13..23, and the hour itself for hours 1..12. A leading hour-tens zero is always
//     shown, never blanked.
//   Display in SET_H / SET_M: digits show shadow_h:shadow_m with the same 12/24-hour rule; disp1 and disp0
//     show a dash (segment g only). The pair being edited is blanked (all segments 0) while blink phase = 1.
//     The blink phase toggles every BLINK_DIV cycles and is forced to 0 when the FSM is in RUN.
//   Display path is combinational from registered state; no added latency. Time outputs come directly
//     from registers. Reset in the middle of an edit discards the shadow values and returns to RUN at 00:00:00.
// TESTING
//   T1 TICK_DIV = 4: reset, then run 240 cycles -> seconds = 0 and minutes = 1; sec_tick period is 4 cycles.
//   T2 Load 23:59 via load_valid, then 4*60 cycles -> time reads 00:00:00 with is_pm = 0, after passing
//     through 23:59:59 with is_pm = 1.
//   T3 At 10:20: set, up x15 -> shadow_h = 1. Then set, down x21 -> shadow_m = 59. Then set -> 01:59:00,
//     propagate high for exactly 1 cycle, FSM back to RUN.
//   T4 mode_12h = 1: hours 0 / 12 / 13 -> disp5..4 show "12" / "12" / "01". is_pm = 0 / 1 / 1.
//   T5 In SET_M: up and down together -> no change. set with up -> FSM goes to RUN and the up is dropped.
//     load_valid in SET_H -> ignored. load of 24:00 in RUN -> ignored.
//   T6 Assert reset asynchronously in SET_M, between clk edges -> outputs reset immediately; after release,
//     FSM in RUN, time 00:00:00, propagate stays 0.

Source files
------------

// File: rtl/clock_hms_param.sv
// Hour/minute/second timekeeper with a set state machine, 12/24-hour display mode,
// an external time-load port and a six-digit 7-segment display path.
module clock_hms_param #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int BLINK_DIV = 12_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pulsed_set,
  input  logic       pulsed_up,
  input  logic       pulsed_down,
  input  logic       mode_12h,
  input  logic       load_valid,
  input  logic [4:0] load_hours,
  input  logic [5:0] load_minutes,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       is_pm,
  output logic [1:0] current_state,
  output logic       propagate,
  output logic [6:0] disp5,
  output logic [6:0] disp4,
  output logic [6:0] disp3,
  output logic [6:0] disp2,
  output logic [6:0] disp1,
  output logic [6:0] disp0
);

  localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(TICK_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SET_H = 2'd1,
    ST_SET_M = 2'd2
  } state_t;

  state_t             state;
  logic [DIV_W-1:0]   div_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink;
  logic [4:0]         shadow_h;
  logic [5:0]         shadow_m;

  logic sec_tick;
  logic commit;
  logic load_ok;
  logic edit_up;
  logic edit_down;

  // Control inputs are single-cycle pulses sampled on the rising edge; there is no
  // backpressure. load_valid is accepted only in RUN, only when both fields are in
  // range and only when pulsed_set is low; otherwise the pulse is simply dropped.
  assign sec_tick  = (div_cnt == DIV_LAST);
  assign commit    = (state == ST_SET_M) && pulsed_set;
  assign load_ok   = (state == ST_RUN) && load_valid && !pulsed_set &&
                     (load_hours <= 5'd23) && (load_minutes <= 6'd59);
  assign edit_up   = pulsed_up && !pulsed_down && !pulsed_set;
  assign edit_down = pulsed_down && !pulsed_up && !pulsed_set;

  assign current_state = state;
  assign is_pm         = (hours >= 5'd12);

  // Timekeeping: a commit or load restarts the second, and beats a coincident tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hours   <= 5'd0;
      minutes <= 6'd0;
      seconds <= 6'd0;
      div_cnt <= '0;
    end else if (commit) begin
      hours   <= shadow_h;
      minutes <= shadow_m;
      seconds <= 6'd0;
      div_cnt <= '0;
    end else if (load_ok) begin
      hours   <= load_hours;
      minutes <= load_minutes;
      seconds <= 6'd0;
      div_cnt <= '0;
    end else if (sec_tick) begin
      div_cnt <= '0;
      if (seconds == 6'd59) begin
        seconds <= 6'd0;
        if (minutes == 6'd59) begin
          minutes <= 6'd0;
          hours   <= (hours == 5'd23) ? 5'd0 : hours + 5'd1;
        end else begin
          minutes <= minutes + 6'd1;
        end
      end else begin
        seconds <= seconds + 6'd1;
      end
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_RUN;
      shadow_h  <= 5'd0;
      shadow_m  <= 6'd0;
      propagate <= 1'b0;
    end else begin
      propagate <= commit;
      case (state)
        ST_RUN: begin
          if (pulsed_set) begin
            state    <= ST_SET_H;
            shadow_h <= hours;
            shadow_m <= minutes;
          end
        end
        ST_SET_H: begin
          if (pulsed_set) begin
            state <= ST_SET_M;
          end else if (edit_up) begin
            shadow_h <= (shadow_h == 5'd23) ? 5'd0 : shadow_h + 5'd1;
          end else if (edit_down) begin
            shadow_h <= (shadow_h == 5'd0) ? 5'd23 : shadow_h - 5'd1;
          end
        end
        ST_SET_M: begin
          if (pulsed_set) begin
            state <= ST_RUN;
          end else if (edit_up) begin
            shadow_m <= (shadow_m == 6'd59) ? 6'd0 : shadow_m + 6'd1;
          end else if (edit_down) begin
            shadow_m <= (shadow_m == 6'd0) ? 6'd59 : shadow_m - 6'd1;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // Blink phase runs only while editing; it is cleared on the commit edge too so RUN never sees it set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if ((state == ST_RUN) || commit) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink     <= ~blink;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

  function automatic logic [5:0] tens_of(input logic [5:0] v);
    if (v >= 6'd60)      return 6'd6;
    else if (v >= 6'd50) return 6'd5;
    else if (v >= 6'd40) return 6'd4;
    else if (v >= 6'd30) return 6'd3;
    else if (v >= 6'd20) return 6'd2;
    else if (v >= 6'd10) return 6'd1;
    else                 return 6'd0;
  endfunction

  function automatic logic [5:0] units_of(input logic [5:0] v);
    return v - tens_of(v) * 6'd10;
  endfunction

  // Segment order is {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg7(input logic [5:0] d);
    case (d)
      6'd0:    return 7'b0111111;
      6'd1:    return 7'b0000110;
      6'd2:    return 7'b1011011;
      6'd3:    return 7'b1001111;
      6'd4:    return 7'b1100110;
      6'd5:    return 7'b1101101;
      6'd6:    return 7'b1111101;
      6'd7:    return 7'b0000111;
      6'd8:    return 7'b1111111;
      6'd9:    return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  logic       editing;
  logic [5:0] show_h;
  logic [5:0] show_m;
  logic [5:0] hour_disp;

  always_comb begin
    editing   = (state != ST_RUN);
    show_h    = editing ? {1'b0, shadow_h} : {1'b0, hours};
    show_m    = editing ? shadow_m : minutes;
    hour_disp = show_h;
    if (mode_12h) begin
      if (show_h == 6'd0)
        hour_disp = 6'd12;
      else if (show_h > 6'd12)
        hour_disp = show_h - 6'd12;
    end

    disp5 = seg7(tens_of(hour_disp));
    disp4 = seg7(units_of(hour_disp));
    disp3 = seg7(tens_of(show_m));
    disp2 = seg7(units_of(show_m));
    disp1 = editing ? SEG_DASH : seg7(tens_of(seconds));
    disp0 = editing ? SEG_DASH : seg7(units_of(seconds));

    if ((state == ST_SET_H) && blink) begin
      disp5 = SEG_BLANK;
      disp4 = SEG_BLANK;
    end
    if ((state == ST_SET_M) && blink) begin
      disp3 = SEG_BLANK;
      disp2 = SEG_BLANK;
    end
  end

endmodule

// File: tb/tb_clock_hms_param.sv
// Bench for clock_hms_param: directed scenarios plus random pulses, checked every cycle
// against a seconds-of-day reference model.
module tb_clock_hms_param;

  localparam int TICK_DIV  = 4;
  localparam int BLINK_DIV = 3;
  localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pulsed_set = 1'b0;
  logic       pulsed_up = 1'b0;
  logic       pulsed_down = 1'b0;
  logic       mode_12h = 1'b0;
  logic       load_valid = 1'b0;
  logic [4:0] load_hours = 5'd0;
  logic [5:0] load_minutes = 6'd0;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       is_pm;
  logic [1:0] current_state;
  logic       propagate;
  logic [6:0] disp5, disp4, disp3, disp2, disp1, disp0;

  int total = 0;
  int bad = 0;
  string phase = "reset";

  // Reference model: time as seconds of day, divider as a cycle count.
  int m_state, m_secs, m_div, m_sh, m_sm, m_prop, m_bl;

  clock_hms_param #(.TICK_DIV(TICK_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .reset(reset),
    .pulsed_set(pulsed_set), .pulsed_up(pulsed_up), .pulsed_down(pulsed_down),
    .mode_12h(mode_12h), .load_valid(load_valid),
    .load_hours(load_hours), .load_minutes(load_minutes),
    .hours(hours), .minutes(minutes), .seconds(seconds), .is_pm(is_pm),
    .current_state(current_state), .propagate(propagate),
    .disp5(disp5), .disp4(disp4), .disp3(disp3),
    .disp2(disp2), .disp1(disp1), .disp0(disp0)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s/%s: observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_secs = 0; m_div = 0; m_sh = 0; m_sm = 0; m_prop = 0; m_bl = 0;
  endtask

  task automatic model_step();
    int o_state, o_secs, o_sh, o_sm;
    bit commit, load_ok;
    o_state = m_state; o_secs = m_secs; o_sh = m_sh; o_sm = m_sm;
    commit  = pulsed_set && (o_state == 2);
    load_ok = (o_state == 0) && load_valid && !pulsed_set &&
              (load_hours < 24) && (load_minutes < 60);
    m_prop = commit ? 1 : 0;
    if (commit) begin
      m_secs = o_sh * 3600 + o_sm * 60; m_div = 0;
    end else if (load_ok) begin
      m_secs = int'(load_hours) * 3600 + int'(load_minutes) * 60; m_div = 0;
    end else if (m_div == TICK_DIV - 1) begin
      m_div = 0; m_secs = (m_secs + 1) % 86400;
    end else begin
      m_div++;
    end
    if (pulsed_set) begin
      if (o_state == 0) begin
        m_sh = o_secs / 3600; m_sm = (o_secs / 60) % 60;
      end
      m_state = (o_state + 1) % 3;
    end else if (pulsed_up != pulsed_down) begin
      if (o_state == 1) m_sh = (o_sh + (pulsed_up ? 1 : 23)) % 24;
      else if (o_state == 2) m_sm = (o_sm + (pulsed_up ? 1 : 59)) % 60;
    end
    if (o_state == 0 || commit) m_bl = 0;
    else m_bl++;
  endtask

  function automatic logic [41:0] exp_disp();
    int h, m, s, hd;
    logic [6:0] d5, d4, d3, d2, d1, d0;
    bit blink;
    if (m_state == 0) begin
      h = m_secs / 3600; m = (m_secs / 60) % 60; s = m_secs % 60;
    end else begin
      h = m_sh; m = m_sm; s = 0;
    end
    hd = h;
    if (mode_12h) hd = (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
    d5 = SEG_TAB[hd / 10]; d4 = SEG_TAB[hd % 10];
    d3 = SEG_TAB[m / 10];  d2 = SEG_TAB[m % 10];
    if (m_state == 0) begin
      d1 = SEG_TAB[s / 10]; d0 = SEG_TAB[s % 10];
    end else begin
      d1 = 7'h40; d0 = 7'h40;
    end
    blink = ((m_bl / BLINK_DIV) % 2) == 1;
    if (m_state == 1 && blink) begin d5 = 7'h00; d4 = 7'h00; end
    if (m_state == 2 && blink) begin d3 = 7'h00; d2 = 7'h00; end
    return {d5, d4, d3, d2, d1, d0};
  endfunction

  task automatic check_all();
    logic [41:0] ed;
    ed = exp_disp();
    chk("hours",   hours,   m_secs / 3600);
    chk("minutes", minutes, (m_secs / 60) % 60);
    chk("seconds", seconds, m_secs % 60);
    chk("is_pm",   is_pm,   (m_secs >= 12 * 3600) ? 1 : 0);
    chk("state",   current_state, m_state);
    chk("propagate", propagate, m_prop);
    chk("disp5", disp5, ed[41:35]);
    chk("disp4", disp4, ed[34:28]);
    chk("disp3", disp3, ed[27:21]);
    chk("disp2", disp2, ed[20:14]);
    chk("disp1", disp1, ed[13:7]);
    chk("disp0", disp0, ed[6:0]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic pulse(input bit s, input bit u, input bit d, input bit lv,
                       input int lh, input int lm);
    pulsed_set = s; pulsed_up = u; pulsed_down = d; load_valid = lv;
    load_hours = 5'(lh); load_minutes = 6'(lm);
    cycle();
    pulsed_set = 0; pulsed_up = 0; pulsed_down = 0; load_valid = 0;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    chk("reset_hours", hours, 0);
    chk("reset_state", current_state, 0);
    @(negedge clk);
    reset = 1'b0;

    phase = "t1";
    run(240);
    chk("t1_seconds", seconds, 0);
    chk("t1_minutes", minutes, 1);

    phase = "t2";
    pulse(0, 0, 0, 1, 23, 59);
    run(4 * 59);
    chk("t2_hours_59", hours, 23);
    chk("t2_seconds_59", seconds, 59);
    chk("t2_pm_59", is_pm, 1);
    run(4);
    chk("t2_wrap_hours", hours, 0);
    chk("t2_wrap_minutes", minutes, 0);
    chk("t2_wrap_seconds", seconds, 0);
    chk("t2_wrap_pm", is_pm, 0);

    phase = "t3";
    pulse(0, 0, 0, 1, 10, 20);
    pulse(1, 0, 0, 0, 0, 0);
    repeat (15) pulse(0, 1, 0, 0, 0, 0);
    pulse(1, 0, 0, 0, 0, 0);
    repeat (21) pulse(0, 0, 1, 0, 0, 0);
    pulse(1, 0, 0, 0, 0, 0);
    chk("t3_hours", hours, 1);
    chk("t3_minutes", minutes, 59);
    chk("t3_seconds", seconds, 0);
    chk("t3_prop_hi", propagate, 1);
    chk("t3_state", current_state, 0);
    cycle();
    chk("t3_prop_lo", propagate, 0);

    phase = "t4";
    mode_12h = 1'b1;
    pulse(0, 0, 0, 1, 0, 0);
    chk("t4_h0_tens", disp5, 7'h06);
    chk("t4_h0_units", disp4, 7'h5B);
    chk("t4_h0_pm", is_pm, 0);
    pulse(0, 0, 0, 1, 12, 0);
    chk("t4_h12_tens", disp5, 7'h06);
    chk("t4_h12_units", disp4, 7'h5B);
    chk("t4_h12_pm", is_pm, 1);
    pulse(0, 0, 0, 1, 13, 0);
    chk("t4_h13_tens", disp5, 7'h3F);
    chk("t4_h13_units", disp4, 7'h06);
    chk("t4_h13_pm", is_pm, 1);
    mode_12h = 1'b0;
    cycle();

    phase = "t5";
    pulse(0, 0, 0, 1, 5, 30);
    pulse(1, 0, 0, 0, 0, 0);
    pulse(1, 0, 0, 0, 0, 0);
    pulse(0, 1, 1, 0, 0, 0);
    pulse(1, 1, 0, 0, 0, 0);
    chk("t5_set_wins_state", current_state, 0);
    chk("t5_set_wins_min", minutes, 30);
    chk("t5_set_wins_hr", hours, 5);
    pulse(1, 0, 0, 0, 0, 0);
    pulse(0, 0, 0, 1, 7, 7);
    chk("t5_load_in_seth", hours, 5);
    chk("t5_seth_state", current_state, 1);
    pulse(1, 0, 0, 0, 0, 0);
    pulse(1, 0, 0, 0, 0, 0);
    pulse(0, 0, 0, 1, 24, 0);
    chk("t5_bad_load_hr", hours, 5);
    pulse(0, 0, 0, 1, 3, 60);
    chk("t5_bad_load_min", minutes, 30);
    pulse(1, 1, 0, 1, 9, 9);
    chk("t5_set_beats_load", current_state, 1);

    phase = "t6";
    pulse(1, 0, 0, 0, 0, 0);
    pulse(0, 1, 0, 0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;
    run(10);
    chk("t6_prop", propagate, 0);

    phase = "random";
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 63) == 0) mode_12h = ~mode_12h;
      pulse($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
            int'($urandom_range(0, 31)), int'($urandom_range(0, 63)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
